// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and helpers for the multi-digit counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Codes 10..15 are not BCD; squash them to the largest legal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
  endfunction

  function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
    return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD decade: clamped parallel load, up/down step with wrap, limit flags for the carry chain.
module digito_bcd
  import bcd_pkg::*;
(
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (step) begin
      digit_d = up ? bcd_inc(digit_q) : bcd_dec(digit_q);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/contador_bcd.sv
// Multi-digit BCD up/down counter with parallel load, wrap pulse and a time-multiplexed
// single-digit scan output (A = MSB ... D = LSB of the selected digit).
module contador_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned SCAN_DIV   = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_en,
  input  logic                    in_up,
  input  logic                    in_load,
  input  logic [4*NUM_DIGITS-1:0] in_load_val,
  output logic [4*NUM_DIGITS-1:0] out_count,
  output logic                    out_A,
  output logic                    out_B,
  output logic                    out_C,
  output logic                    out_D,
  output logic [NUM_DIGITS-1:0]   out_sel,
  output logic                    out_valid,
  output logic                    out_tc
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ---------------------------------------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] at_max, at_min;
  // chain[i]: a step is allowed and every digit below i sits at its wrap limit.
  logic [NUM_DIGITS:0]   chain;
  logic                  wrap;

  assign chain[0] = in_en & ~in_load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & (in_up ? at_max[i] : at_min[i]);

    digito_bcd u_digit (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .load       (in_load),
      .load_digit (in_load_val[4*i +: 4]),
      .step       (chain[i]),
      .up         (in_up),
      .digit      (out_count[4*i +: 4]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i])
    );
  end

  assign wrap = chain[NUM_DIGITS];

  logic tc_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= wrap;
    end
  end

  assign out_tc = tc_q;

  // ---------------------------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------------------------
  logic [DivW-1:0]       div_q, div_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d, sel_rot;
  logic                  started_q;
  logic                  valid_q, valid_d;
  logic                  div_last;
  bcd_digit_t            scan_q, scan_d;

  assign div_last = (div_q == DivW'(SCAN_DIV - 1));
  assign sel_rot  = (sel_q << 1) | (sel_q >> (NUM_DIGITS - 1));

  // The first edge after reset opens slot 0 (strobe, divider held at 0) so that every slot,
  // including the first, spans SCAN_DIV full cycles starting at its strobe.
  always_comb begin
    div_d   = div_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (!started_q) begin
      valid_d = 1'b1;
    end else if (div_last) begin
      div_d   = '0;
      sel_d   = sel_rot;
      valid_d = 1'b1;
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  // The scanned digit mirrors the registered count, so it lags out_count by one cycle and
  // keeps following the held digit while its slot lasts.
  always_comb begin
    scan_d = BCD_MIN;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_d[i]) begin
        scan_d = out_count[4*i +: 4];
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      started_q <= 1'b0;
      div_q     <= '0;
      sel_q     <= NUM_DIGITS'(1);
      valid_q   <= 1'b0;
      scan_q    <= BCD_MIN;
    end else begin
      started_q <= 1'b1;
      div_q     <= div_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      scan_q    <= scan_d;
    end
  end

  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign out_A     = scan_q[3];
  assign out_B     = scan_q[2];
  assign out_C     = scan_q[1];
  assign out_D     = scan_q[0];

endmodule

// File: tb/tb_contador_bcd.sv
// Scoreboard bench for contador_bcd: a SCAN_DIV=4 instance and a SCAN_DIV=1 instance on shared
// inputs, directed count vectors with hand-computed results and a reference scan sequence.
module tb_contador_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] count4, count1;
  logic       a4, b4, c4, d4, a1, b1, c1, d1;
  logic [1:0] sel4, sel1;
  logic       valid4, valid1, tc4, tc1;

  always #5 clk = ~clk;

  contador_bcd #(.NUM_DIGITS(2), .SCAN_DIV(4)) dut (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_up(up), .in_load(load), .in_load_val(load_val),
    .out_count(count4), .out_A(a4), .out_B(b4), .out_C(c4), .out_D(d4),
    .out_sel(sel4), .out_valid(valid4), .out_tc(tc4)
  );

  contador_bcd #(.NUM_DIGITS(2), .SCAN_DIV(1)) dut_fast (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_up(up), .in_load(load), .in_load_val(load_val),
    .out_count(count1), .out_A(a1), .out_B(b1), .out_C(c1), .out_D(d1),
    .out_sel(sel1), .out_valid(valid1), .out_tc(tc1)
  );

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Downstream excess-3 converter, written out as a table.
  function automatic logic [3:0] xs3(input logic [3:0] d);
    case (d)
      4'd0: return 4'd3;   4'd1: return 4'd4;   4'd2: return 4'd5;   4'd3: return 4'd6;
      4'd4: return 4'd7;   4'd5: return 4'd8;   4'd6: return 4'd9;   4'd7: return 4'd10;
      4'd8: return 4'd11;  4'd9: return 4'd12;  default: return 4'd15;
    endcase
  endfunction

  // Monitor: one scoreboard entry per clock edge; scan expectations come from a reference
  // slot sequence fed with the previous edge's expected count.
  logic       m_started, m_started1;
  logic [1:0] m_div, m_sel, m_sel1;
  logic [7:0] m_prev;

  always @(negedge clk) begin
    if (rst) begin
      m_started  = 1'b0;
      m_started1 = 1'b0;
      m_div      = 2'd0;
      m_sel      = 2'b01;
      m_sel1     = 2'b01;
      m_prev     = 8'h00;
    end else if (sb_q.size() > 0) begin
      exp_t       e;
      logic       v;
      logic [3:0] dig, dig1;
      e = sb_q.pop_front();
      if (!m_started) begin
        m_started = 1'b1;
        v = 1'b1;
      end else if (m_div == 2'd3) begin
        m_div = 2'd0;
        m_sel = {m_sel[0], m_sel[1]};
        v = 1'b1;
      end else begin
        m_div = m_div + 2'd1;
        v = 1'b0;
      end
      if (!m_started1) m_started1 = 1'b1;
      else m_sel1 = {m_sel1[0], m_sel1[1]};
      dig  = m_sel[0]  ? m_prev[3:0] : m_prev[7:4];
      dig1 = m_sel1[0] ? m_prev[3:0] : m_prev[7:4];

      chk("count",        count4,               e.count);
      chk("tc",           tc4,                  e.tc);
      chk("sel",          sel4,                 m_sel);
      chk("valid",        valid4,               v);
      chk("scan_digit",   {a4, b4, c4, d4},     dig);
      chk("xs3_of_scan",  xs3({a4, b4, c4, d4}), dig + 4'd3);
      chk("fast_count",   count1,               e.count);
      chk("fast_tc",      tc1,                  e.tc);
      chk("fast_sel",     sel1,                 m_sel1);
      chk("fast_valid",   valid1,               1'b1);
      chk("fast_digit",   {a1, b1, c1, d1},     dig1);
      m_prev = e.count;
    end
  end

  task automatic step(input logic ld, input logic [7:0] v, input logic e, input logic u,
                      input logic [7:0] exp_c, input logic exp_tc);
    load = ld; load_val = v; en = e; up = u;
    sb_q.push_back('{count: exp_c, tc: exp_tc});
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] exp_c);
    step(1'b0, 8'h00, 1'b0, 1'b1, exp_c, 1'b0);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Reset mid-count: 57 -> 58 -> 59 -> 60, then a slot change onto the tens digit.
    step(1'b1, 8'h57, 1'b0, 1'b1, 8'h57, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h58, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h59, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 1'b0);
    hold(8'h60);
    drain();
    rst = 1'b1;
    #1;
    chk("rst_count", count4, 8'h00);
    chk("rst_sel",   sel4,   2'b01);
    chk("rst_valid", valid4, 1'b0);
    chk("rst_tc",    tc4,    1'b0);
    chk("rst_abcd",  {a4, b4, c4, d4}, 4'b0000);
    chk("rst_fast_count", count1, 8'h00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Up wrap.
    step(1'b1, 8'h98, 1'b0, 1'b1, 8'h98, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    hold(8'h00);

    // Down wrap and borrow across the decade.
    step(1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1);
    hold(8'h99);
    step(1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0);

    // Clamp and load priority over enable.
    step(1'b1, 8'hFA, 1'b1, 1'b1, 8'h99, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b1, 8'h39, 1'b0);
    step(1'b1, 8'hB2, 1'b1, 1'b0, 8'h92, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

    // Direction changing every cycle, back-to-back wraps.
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    hold(8'h00);

    // Scan of a held value.
    step(1'b1, 8'h42, 1'b0, 1'b1, 8'h42, 1'b0);
    repeat (9) hold(8'h42);

    // Live update while a slot is held.
    step(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0);
    repeat (3) hold(8'h11);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
